mdu_seq: RTL
============

# mdu_seq

Iterative multiply/divide sequencer beside the EX-stage ALU in the pipelined CPU. It takes a MULT/MULTU/DIV/DIVU/MTHI/MTLO request from EX and runs a radix-2 shift-add or restoring-divide sequence over a fixed number of cycles. It holds `busy` so the hazard unit stalls the pipeline, and owns the architectural HI/LO registers. The ALU stays single-cycle and combinational; every multi-cycle arithmetic operation goes through this block.

## Interface
Parameters:
- `W`, 32, operand width; HI and LO are each `W` bits.

Ports:
- `clk`  in  1  clock, all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request strobe from EX; sampled only while idle
- `op`  in  3  `MDU_OP_MULT`, `MDU_OP_MULTU`, `MDU_OP_DIV`, `MDU_OP_DIVU`, `MDU_OP_MTHI`, `MDU_OP_MTLO`
- `src_a`  in  W  rs value (multiplicand / dividend / MTHI-MTLO data)
- `src_b`  in  W  rt value (multiplier / divisor)
- `flush`  in  1  abort the operation in flight (exception or branch squash)
- `busy`  out  1  high while the sequence runs
- `done`  out  1  one-cycle pulse when HI/LO take a MULT/DIV result
- `div_by_zero`  out  1  one-cycle pulse with `done` for a DIV/DIVU with `src_b==0`
- `hi`  out  W  HI register
- `lo`  out  W  LO register

## Operation
- States: `IDLE`, `PREP`, `CALC`, `FIX`.
- **IDLE**
  - `start` with MULT/MULTU/DIV/DIVU: latch operands and op, go to `PREP`.
  - `start` with MTHI/MTLO: write `src_a` to `hi`/`lo` at that edge; stay in `IDLE`; no `done`.
  - Undefined `op`: ignored.
- **PREP**
  - Signed ops: take absolute values of the operands and record the result signs.
  - Quotient sign = `a[W-1]^b[W-1]`; remainder sign = `a[W-1]`.
  - Clear the 2W accumulator and a 5-bit iteration counter, then go to `CALC`.
- **CALC**: one iteration per cycle, 32 iterations (counter 0..31).
  - Multiply: if the multiplier LSB is 1, add the multiplicand into the accumulator's upper W+1 bits; then shift right 1.
  - Divide (restoring): shift the remainder:quotient pair left 1, then do a W+1-bit trial subtract. If non-negative, keep the difference and set the quotient LSB to 1.
  - When counter = 31, go to `FIX`.
- **FIX**: apply sign correction, write `hi`/`lo`, pulse `done`, go to `IDLE`.
  - Multiply: {hi,lo} = 2W-bit product; two's-complement negated if the product is negative.
  - Divide: lo = quotient, truncated toward zero; hi = remainder, taking the dividend's sign.
- Divide by zero: still runs the full sequence. Result is forced to `lo=32'hFFFF_FFFF`, `hi=src_a`, and `div_by_zero` pulses with `done`.
- Signed overflow `32'h8000_0000 / -1`: `lo=32'h8000_0000`, `hi=0`. Falls out of the magnitude arithmetic; no special case.
- `start` while `busy`: ignored. The hazard unit must not issue one.
- `flush` (any state other than `IDLE`): return to `IDLE` at the next edge; `hi`/`lo` unchanged; no `done`.
- `flush` takes priority over `start` and over a FIX write in the same cycle.
- Reset: state `IDLE`, `busy=0`, `done=0`, `div_by_zero=0`, `hi=0`, `lo=0`, internal registers 0. Reset may assert mid-sequence; the block is idle immediately.

## Timing
- Counting the `start` cycle as cycle 0 for MULT/DIV:
  - `PREP` runs in cycle 1.
  - `CALC` runs in cycles 2–33.
  - `FIX` runs in cycle 34.
  - `hi`/`lo` show the new values and `done=1` in cycle 35.
- `busy` is a registered output (state != `IDLE`), high in cycles 1–34. A new `start` is accepted in cycle 35.
- MTHI/MTLO: new value visible in cycle 1; `busy` stays 0.
- `hi`/`lo` are plain register outputs with no combinational path from inputs. A reader in cycle 35 sees the new result.

## Configuration
- `MDU_FAST_MUL_EN` defined: multiply uses a single-cycle 2W-bit `*` in `PREP` and skips `CALC`.
  - `FIX` is in cycle 2, `done` in cycle 3, `busy` in cycles 1–2.
  - Divide timing is unchanged.
- Not defined: all ops use the 35-cycle iterative path, and no multiplier is inferred.

## Structure
- Shared header/package (alongside the ALU op constants):
  - `MDU_OP_*` codes
  - `MDU_ST_*` state encodings (2 bits)
  - `MDU_ITER = 32`
- Sub-module `mdu_addsub`:
  - W+1-bit add/subtract (`sub` select, carry/sign out).
  - Shared by the multiply add step and the divide trial subtract.
  - Also used for the PREP/FIX negations.

## Test plan
- Reset mid-CALC of DIV: deassert `rst_n` at cycle 10 -> `busy=0`, `hi=lo=0` immediately; no `done` ever.
- MULT `src_a=32'hFFFF_FFFE` (-2), `src_b=3` -> cycle 35: `hi=32'hFFFF_FFFF`, `lo=32'hFFFF_FFFA`, `done=1` for exactly one cycle. MULTU with the same operands -> `hi=2`, `lo=32'hFFFF_FFFA`.
- DIV `-7/2` -> `lo=32'hFFFF_FFFD`, `hi=32'hFFFF_FFFF`. DIVU `100/7` -> `lo=14`, `hi=2`. DIV `32'h8000_0000/-1` -> `lo=32'h8000_0000`, `hi=0`.
- DIVU `5/0` -> cycle 35: `lo=32'hFFFF_FFFF`, `hi=5`, `div_by_zero=1` with `done=1`.
- MTHI `32'hDEAD_BEEF` -> `hi` updated in cycle 1, `busy` never set. Then MULT with `flush` at cycle 20 -> `busy` drops in cycle 21, `hi` still `32'hDEAD_BEEF`, no `done`. A `start` in cycle 21 is accepted.
- Back-to-back: MULT, then a second `start` in cycle 35 -> second `done` in cycle 70. A `start` pulsed during cycles 1–34 is ignored.

Source files
------------

// File: rtl/mdu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdu_seq_pkg
// Purpose  : Shared constants for the iterative multiply/divide sequencer.
//            Holds the MDU op codes, the 2-bit sequencer state encodings,
//            the iteration count, and small op-classification helpers.
// Revision : 1.0 - initial release
// ============================================================================
package mdu_seq_pkg;

    // MDU request codes presented by EX on 'op'
    localparam logic [2:0] MDU_OP_MULT  = 3'd0;
    localparam logic [2:0] MDU_OP_MULTU = 3'd1;
    localparam logic [2:0] MDU_OP_DIV   = 3'd2;
    localparam logic [2:0] MDU_OP_DIVU  = 3'd3;
    localparam logic [2:0] MDU_OP_MTHI  = 3'd4;
    localparam logic [2:0] MDU_OP_MTLO  = 3'd5;

    // Sequencer states
    typedef enum logic [1:0] {
        MDU_ST_IDLE = 2'd0,
        MDU_ST_PREP = 2'd1,
        MDU_ST_CALC = 2'd2,
        MDU_ST_FIX  = 2'd3
    } mdu_state_t;

    // Radix-2 iterations per multiply/divide
    localparam int MDU_ITER = 32;

    // Multi-cycle arithmetic ops (the ones that run the sequence)
    function automatic logic is_md_op(input logic [2:0] o);
        return (o == MDU_OP_MULT) || (o == MDU_OP_MULTU) ||
               (o == MDU_OP_DIV)  || (o == MDU_OP_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] o);
        return (o == MDU_OP_DIV) || (o == MDU_OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] o);
        return (o == MDU_OP_MULT) || (o == MDU_OP_DIV);
    endfunction

endpackage : mdu_seq_pkg
`default_nettype wire

// File: rtl/mdu_addsub.sv
`default_nettype none
// ============================================================================
// Module   : mdu_addsub
// Purpose  : N-bit adder/subtractor used by the MDU for the multiply add
//            step, the divide trial subtract and the sign-fix negations.
// Ports    : i_a, i_b  - N-bit operands
//            i_sub     - 1: o_sum = i_a - i_b, 0: o_sum = i_a + i_b
//            o_sum     - N-bit result
//            o_cout    - carry out; on subtract, 1 means i_a >= i_b (unsigned)
//            o_sign    - MSB of o_sum
// Revision : 1.0 - initial release
// ============================================================================
module mdu_addsub #(
    parameter int N = 33
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_sub,
    output logic [N-1:0] o_sum,
    output logic         o_cout,
    output logic         o_sign
);

    logic [N-1:0] w_b_eff;
    logic [N:0]   w_full;

    // Subtract as a + ~b + 1 so the carry doubles as a "no borrow" flag
    assign w_b_eff = i_sub ? ~i_b : i_b;
    assign w_full  = {1'b0, i_a} + {1'b0, w_b_eff} + {{N{1'b0}}, i_sub};
    assign o_sum   = w_full[N-1:0];
    assign o_cout  = w_full[N];
    assign o_sign  = w_full[N-1];

endmodule : mdu_addsub
`default_nettype wire

// File: rtl/mdu_seq.sv
`default_nettype none
// ============================================================================
// Module   : mdu_seq
// Purpose  : Iterative multiply/divide sequencer owning the HI/LO registers.
//            Radix-2 shift-add multiply and restoring divide, 32 iterations,
//            start->done latency of 35 cycles.
// Ports    : clk, rst_n (async, active low)
//            start/op/src_a/src_b - request from EX (sampled only when idle)
//            flush                - abort the sequence in flight
//            busy                 - registered, high while not idle
//            done, div_by_zero    - one-cycle result pulses
//            hi, lo               - architectural HI/LO registers
// Build    : MDU_FAST_MUL_EN - multiplies use a single-cycle '*' in PREP
//            and skip CALC (done 3 cycles after start). Undefined by default.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [W-1:0] src_a,
    input  logic [W-1:0] src_b,
    input  logic         flush,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    mdu_state_t     r_state, w_state_nxt;
    logic           r_busy, r_done, r_dbz;
    logic [W-1:0]   r_hi, r_lo;
    logic [2:0]     r_op;
    logic [W-1:0]   r_a;        // raw operand, then magnitude after PREP
    logic [W-1:0]   r_b;        // multiplier (shifts right) or divisor
    logic [W-1:0]   r_srca;     // original dividend for the divide-by-zero result
    logic [2*W-1:0] r_acc;      // product, or remainder:quotient pair
    logic [4:0]     r_cnt;
    logic           r_neg_res;  // product / quotient must be negated
    logic           r_neg_rem;  // remainder must be negated

    logic           w_is_div, w_is_sgn;
    logic [W:0]     w_step_a, w_step_b, w_step_sum;
    logic           w_step_sub, w_step_cout, w_step_sign;
    logic [W:0]     w_aux_b, w_aux_sum;
    logic           w_aux_cout, w_aux_sign;
    logic [2*W-1:0] w_wide_sum;
    logic           w_wide_cout, w_wide_sign;
    logic [W-1:0]   w_mag_a, w_mag_b;
    logic [W:0]     w_mul_hi;
    logic [W-1:0]   w_rem, w_quo;
    logic [4:0]     w_unused_bits;

    assign w_is_div = is_div_op(r_op);
    assign w_is_sgn = is_signed_op(r_op);

    // The step unit is time-shared: |a| in PREP, add/trial-subtract in CALC,
    // quotient negation in FIX. The aux unit negates b in PREP and the
    // remainder in FIX.
    always_comb begin
        w_step_a   = {1'b0, r_acc[2*W-1:W]};
        w_step_b   = {1'b0, r_a};
        w_step_sub = 1'b0;
        w_aux_b    = {1'b0, r_acc[2*W-1:W]};
        case (r_state)
            MDU_ST_PREP: begin
                w_step_a   = '0;
                w_step_b   = {r_a[W-1], r_a};
                w_step_sub = 1'b1;
                w_aux_b    = {r_b[W-1], r_b};
            end
            MDU_ST_CALC: begin
                if (w_is_div) begin
                    // Remainder already shifted left by one, with the bit
                    // coming out of the quotient half as its LSB
                    w_step_a   = r_acc[2*W-1:W-1];
                    w_step_b   = {1'b0, r_b};
                    w_step_sub = 1'b1;
                end
            end
            MDU_ST_FIX: begin
                w_step_a   = '0;
                w_step_b   = {1'b0, r_acc[W-1:0]};
                w_step_sub = 1'b1;
            end
            default: ;
        endcase
    end

    mdu_addsub #(.N(W+1)) u_step (
        .i_a    (w_step_a),
        .i_b    (w_step_b),
        .i_sub  (w_step_sub),
        .o_sum  (w_step_sum),
        .o_cout (w_step_cout),
        .o_sign (w_step_sign)
    );

    mdu_addsub #(.N(W+1)) u_aux (
        .i_a    ('0),
        .i_b    (w_aux_b),
        .i_sub  (1'b1),
        .o_sum  (w_aux_sum),
        .o_cout (w_aux_cout),
        .o_sign (w_aux_sign)
    );

    // 2W-bit negation of a signed product
    mdu_addsub #(.N(2*W)) u_wide (
        .i_a    ('0),
        .i_b    (r_acc),
        .i_sub  (1'b1),
        .o_sum  (w_wide_sum),
        .o_cout (w_wide_cout),
        .o_sign (w_wide_sign)
    );

    assign w_unused_bits = {w_aux_sum[W], w_aux_cout, w_aux_sign, w_wide_cout, w_wide_sign ^ w_step_sign};

    assign w_mag_a  = (w_is_sgn && r_a[W-1]) ? w_step_sum[W-1:0] : r_a;
    assign w_mag_b  = (w_is_sgn && r_b[W-1]) ? w_aux_sum[W-1:0]  : r_b;
    assign w_mul_hi = r_b[0] ? w_step_sum : {1'b0, r_acc[2*W-1:W]};
    // Restoring step: keep the difference only when the trial did not borrow
    assign w_rem    = w_step_cout ? w_step_sum[W-1:0] : r_acc[2*W-2:W-1];
    assign w_quo    = {r_acc[W-2:0], w_step_cout};

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MDU_ST_IDLE: begin
                if (start && is_md_op(op)) w_state_nxt = MDU_ST_PREP;
            end
            MDU_ST_PREP: begin
`ifdef MDU_FAST_MUL_EN
                w_state_nxt = w_is_div ? MDU_ST_CALC : MDU_ST_FIX;
`else
                w_state_nxt = MDU_ST_CALC;
`endif
            end
            MDU_ST_CALC: begin
                if (r_cnt == 5'(MDU_ITER - 1)) w_state_nxt = MDU_ST_FIX;
            end
            MDU_ST_FIX:  w_state_nxt = MDU_ST_IDLE;
            default:     w_state_nxt = MDU_ST_IDLE;
        endcase
        if (flush) w_state_nxt = MDU_ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MDU_ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != MDU_ST_IDLE);
        end
    end

    // Datapath and HI/LO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_srca    <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            case (r_state)
                MDU_ST_IDLE: begin
                    if (start && !flush) begin
                        if (op == MDU_OP_MTHI) begin
                            r_hi <= src_a;
                        end else if (op == MDU_OP_MTLO) begin
                            r_lo <= src_a;
                        end else if (is_md_op(op)) begin
                            r_op   <= op;
                            r_a    <= src_a;
                            r_b    <= src_b;
                            r_srca <= src_a;
                        end
                    end
                end
                MDU_ST_PREP: begin
                    r_a       <= w_mag_a;
                    r_b       <= w_mag_b;
                    r_neg_res <= w_is_sgn & (r_a[W-1] ^ r_b[W-1]);
                    r_neg_rem <= w_is_sgn & r_a[W-1];
                    r_cnt     <= '0;
                    if (w_is_div) begin
                        r_acc <= {{W{1'b0}}, w_mag_a};
                    end else begin
`ifdef MDU_FAST_MUL_EN
                        r_acc <= {{W{1'b0}}, w_mag_a} * {{W{1'b0}}, w_mag_b};
`else
                        r_acc <= '0;
`endif
                    end
                end
                MDU_ST_CALC: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (w_is_div) begin
                        r_acc <= {w_rem, w_quo};
                    end else begin
                        r_acc <= {w_mul_hi, r_acc[W-1:1]};
                        r_b   <= r_b >> 1;
                    end
                end
                MDU_ST_FIX: begin
                    if (!flush) begin
                        r_done <= 1'b1;
                        if (w_is_div) begin
                            if (r_b == '0) begin
                                r_lo  <= '1;
                                r_hi  <= r_srca;
                                r_dbz <= 1'b1;
                            end else begin
                                r_lo <= r_neg_res ? w_step_sum[W-1:0] : r_acc[W-1:0];
                                r_hi <= r_neg_rem ? w_aux_sum[W-1:0]  : r_acc[2*W-1:W];
                            end
                        end else begin
                            {r_hi, r_lo} <= r_neg_res ? w_wide_sum : r_acc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule : mdu_seq
`default_nettype wire
